// File: rtl/sreg8_row_sequencer_if.sv
// Handshake/strobe bundle between the row sequencer and its environment
// (frame requester, row buffer read port, shift register, butterfly input).
interface sreg8_row_sequencer_if;
    logic       start;
    logic       busy;
    logic       rd_en;
    logic [2:0] rd_addr;
    logic       ren;
    logic       men;
    logic       dout_valid;
    logic [5:0] dout_idx;
    logic       dout_last;
    logic       done;

    modport master (
        input  start,
        output busy, rd_en, rd_addr, ren, men, dout_valid, dout_idx, dout_last, done
    );

    modport slave (
        output start,
        input  busy, rd_en, rd_addr, ren, men, dout_valid, dout_idx, dout_last, done
    );
endinterface

// File: rtl/sreg8_row_sequencer.sv
// Frame sequencer for the 8-lane row shift register: issues 8 row reads,
// drives load/shift strobes and tags the 64 serial output samples.
module sreg8_row_sequencer #(
    parameter int RD_LAT = 1,
    parameter int ROWS   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    sreg8_row_sequencer_if.master bus
);
    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

    localparam logic [5:0] LAST_ISSUE = 6'((ROWS - 1) * 8);

    state_t            state_q, state_d;
    logic [5:0]        fcnt_q, fcnt_d;
    logic              rd_en_q, rd_en_d;
    logic [2:0]        rd_addr_q, rd_addr_d;
    logic [RD_LAT-1:0] pipe_q;
    logic              ren;
    logic              men_q, men_d;
    logic              valid_q, valid_d;
    logic              last_q, last_d;
    logic [5:0]        idx_q, idx_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start)            state_d = FETCH;
            FETCH:   if (fcnt_q == LAST_ISSUE) state_d = DRAIN;
            DRAIN:   if (last_q)               state_d = DONE;
            DONE:                              state_d = IDLE;
            default:                           state_d = IDLE;
        endcase
    end

    // Decoded from the next state so busy/done come straight from flops.
    always_comb begin
        busy_d = (state_d == FETCH) || (state_d == DRAIN);
        done_d = (state_d == DONE);
    end

    always_comb begin
        fcnt_d    = (state_q == FETCH) ? fcnt_q + 6'd1 : '0;
        rd_en_d   = (state_d == FETCH) && (fcnt_d[2:0] == 3'd0);
        rd_addr_d = rd_en_d ? fcnt_d[5:3] : rd_addr_q;
    end

    assign ren = pipe_q[RD_LAT-1];

    // A load on lane 7 of the previous row continues the index without a bubble.
    always_comb begin
        valid_d = valid_q;
        idx_d   = idx_q;
        if (ren) begin
            valid_d = 1'b1;
            idx_d   = valid_q ? idx_q + 6'd1 : '0;
        end else if (valid_q) begin
            if (idx_q[2:0] == 3'd7) begin
                valid_d = 1'b0;
                idx_d   = '0;
            end else begin
                idx_d = idx_q + 6'd1;
            end
        end
        men_d  = valid_d && (idx_d[2:0] != 3'd7);
        last_d = valid_d && (idx_d == 6'd63);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fcnt_q    <= '0;
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
            pipe_q    <= '0;
            men_q     <= 1'b0;
            valid_q   <= 1'b0;
            last_q    <= 1'b0;
            idx_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            fcnt_q    <= fcnt_d;
            rd_en_q   <= rd_en_d;
            rd_addr_q <= rd_addr_d;
            pipe_q[0] <= rd_en_q;
            for (int unsigned i = 1; i < RD_LAT; i++) pipe_q[i] <= pipe_q[i-1];
            men_q     <= men_d;
            valid_q   <= valid_d;
            last_q    <= last_d;
            idx_q     <= idx_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.busy       = busy_q;
    assign bus.rd_en      = rd_en_q;
    assign bus.rd_addr    = rd_addr_q;
    assign bus.ren        = ren;
    assign bus.men        = men_q;
    assign bus.dout_valid = valid_q;
    assign bus.dout_idx   = idx_q;
    assign bus.dout_last  = last_q;
    assign bus.done       = done_q;
endmodule

// File: tb/tb_sreg8_row_sequencer.sv
// Bench for sreg8_row_sequencer: two instances (RD_LAT 1 and 3), each with a
// row buffer and shift register model whose word r lane k holds 8r+k.
module tb_sreg8_row_sequencer;
    logic clk = 1'b0;
    logic rst;
    logic use3;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    sreg8_row_sequencer_if b1();
    sreg8_row_sequencer_if b3();

    sreg8_row_sequencer #(.RD_LAT(1), .ROWS(8)) dut1 (.clk(clk), .rst(rst), .bus(b1));
    sreg8_row_sequencer #(.RD_LAT(3), .ROWS(8)) dut3 (.clk(clk), .rst(rst), .bus(b3));

    // Row buffer: rd_addr holds between reads, so delaying it by RD_LAT gives the row on the data bus.
    logic [2:0] ap1;
    logic [2:0] ap3 [3];
    logic [5:0] sr1 [8];
    logic [5:0] sr3 [8];

    always @(posedge clk) begin
        ap1    <= b1.rd_addr;
        ap3[0] <= b3.rd_addr;
        ap3[1] <= ap3[0];
        ap3[2] <= ap3[1];
        for (int k = 0; k < 8; k++) begin
            if (b1.ren)      sr1[k] <= 6'({ap1, 3'(k)});
            else if (b1.men) sr1[k] <= (k < 7) ? sr1[k+1] : sr1[k];
            if (b3.ren)      sr3[k] <= 6'({ap3[2], 3'(k)});
            else if (b3.men) sr3[k] <= (k < 7) ? sr3[k+1] : sr3[k];
        end
    end

    logic       s_busy, s_rd_en, s_ren, s_men, s_valid, s_last, s_done;
    logic [2:0] s_rd_addr;
    logic [5:0] s_idx, s_data;

    assign s_busy    = use3 ? b3.busy       : b1.busy;
    assign s_rd_en   = use3 ? b3.rd_en      : b1.rd_en;
    assign s_rd_addr = use3 ? b3.rd_addr    : b1.rd_addr;
    assign s_ren     = use3 ? b3.ren        : b1.ren;
    assign s_men     = use3 ? b3.men        : b1.men;
    assign s_valid   = use3 ? b3.dout_valid : b1.dout_valid;
    assign s_idx     = use3 ? b3.dout_idx   : b1.dout_idx;
    assign s_last    = use3 ? b3.dout_last  : b1.dout_last;
    assign s_done    = use3 ? b3.done       : b1.done;
    assign s_data    = use3 ? sr3[0]        : sr1[0];

    task automatic set_start(input logic v);
        if (use3) b3.start = v;
        else      b1.start = v;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        b1.start = 1'b0;
        b3.start = 1'b0;
        use3 = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            use3 = (i == 1);
            #0;
            checks++;
            if ({s_busy, s_rd_en, s_rd_addr, s_ren, s_men, s_valid, s_idx, s_last, s_done} !== 16'd0)
                begin errors++; $display("FAIL reset_state inst%0d: got %b want 0", i,
                    {s_busy, s_rd_en, s_rd_addr, s_ren, s_men, s_valid, s_idx, s_last, s_done}); end
        end
        use3 = 1'b0;
    endtask

    // Caller is at a negedge; that cycle is cycle 0 (start sampled at its closing edge).
    task automatic frame_scan(input int lat, input int ncyc, input bit hold, input string tag);
        int nren, nmen, nboth, v, rr;
        logic [6:0] got, want;
        nren = 0; nmen = 0; nboth = 0;
        set_start(1'b1);
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge clk);
            if (c == 1 && !hold) set_start(1'b0);
            v  = c - 2 - lat;
            rr = c - 1 - lat;
            want[6] = (c <= 65 + lat);
            want[5] = (c <= 57) && ((c - 1) % 8 == 0);
            want[4] = (rr >= 0) && (rr <= 56) && (rr % 8 == 0);
            want[2] = (v >= 0) && (v <= 63);
            want[3] = want[2] && (v % 8 != 7);
            want[1] = (v == 63);
            want[0] = (c == 66 + lat);
            got = {s_busy, s_rd_en, s_ren, s_men, s_valid, s_last, s_done};
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL %s strobes cyc%0d: got busy/rd/ren/men/val/last/done=%b want %b", tag, c, got, want);
            end
            if (want[5]) begin
                checks++;
                if (s_rd_addr !== 3'((c - 1) / 8)) begin
                    errors++;
                    $display("FAIL %s rd_addr cyc%0d: got %0d want %0d", tag, c, s_rd_addr, (c - 1) / 8);
                end
            end
            if (want[2]) begin
                checks++;
                if (s_idx !== 6'(v) || s_data !== 6'(v)) begin
                    errors++;
                    $display("FAIL %s sample cyc%0d: got idx=%0d data=%0d want %0d", tag, c, s_idx, s_data, v);
                end
            end
            nren  += int'(s_ren);
            nmen  += int'(s_men);
            nboth += int'(s_ren & s_men);
        end
        checks++;
        if (nren != 8 || nmen != 56 || nboth != 0) begin
            errors++;
            $display("FAIL %s strobe_counts: got ren=%0d men=%0d both=%0d want 8 56 0", tag, nren, nmen, nboth);
        end
    endtask

    task automatic test_frame_lat1;
        use3 = 1'b0;
        frame_scan(1, 69, 1'b0, "lat1");
    endtask

    task automatic test_rdlat3;
        use3 = 1'b1;
        frame_scan(3, 71, 1'b0, "lat3");
        use3 = 1'b0;
    endtask

    task automatic test_start_held;
        use3 = 1'b0;
        frame_scan(1, 68, 1'b1, "held");
        @(negedge clk);
        checks++;
        if (!(s_busy === 1'b1 && s_rd_en === 1'b1 && s_rd_addr === 3'd0)) begin
            errors++;
            $display("FAIL held_reaccept cyc69: got busy=%b rd_en=%b addr=%0d want 1 1 0", s_busy, s_rd_en, s_rd_addr);
        end
        b1.start = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset_mid;
        use3 = 1'b0;
        b1.start = 1'b1;
        @(negedge clk);
        b1.start = 1'b0;
        for (int c = 2; c <= 30; c++) @(negedge clk);
        rst = 1'b1;
        for (int c = 31; c <= 35; c++) begin
            @(negedge clk);
            rst = 1'b0;
            checks++;
            if ({s_busy, s_rd_en, s_rd_addr, s_ren, s_men, s_valid, s_idx, s_last, s_done} !== 16'd0) begin
                errors++;
                $display("FAIL midrst_quiet cyc%0d: got %b want 0", c,
                    {s_busy, s_rd_en, s_rd_addr, s_ren, s_men, s_valid, s_idx, s_last, s_done});
            end
        end
        frame_scan(1, 69, 1'b0, "after_rst");
    endtask

    task automatic test_start_rst_same;
        use3 = 1'b0;
        b1.start = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        b1.start = 1'b0;
        rst = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            checks++;
            if ({s_busy, s_rd_en, s_ren, s_valid, s_done} !== 5'd0) begin
                errors++;
                $display("FAIL start_rst_same cyc%0d: got busy/rd/ren/val/done=%b want 0", c,
                    {s_busy, s_rd_en, s_ren, s_valid, s_done});
            end
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset;
        test_frame_lat1;
        test_rdlat3;
        test_start_held;
        test_reset_mid;
        test_start_rst_same;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/sreg8_row_sequencer.md
# sreg8_row_sequencer

Frame sequencer for the 8-lane row shift register in the FFT64 datapath. On `start` it reads the 8 rows of a 64-point frame from the row buffer and drives the row shift register's parallel load (`ren`) and shift (`men`) strobes. The result is one complex sample per cycle for 64 consecutive cycles, tagged with index, valid and last. It sits between the row buffer read port and the serial butterfly input.

## Interface
Parameters:
- `RD_LAT`, 1: row buffer read latency in cycles, from `rd_en` to data on `dinre`/`dinim`. Legal range 1..3.
- `ROWS`, 8: rows per frame. Fixed at 8; the index arithmetic below depends on it.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  frame request. Sampled only in IDLE.
- `busy`  out  1  high from the cycle after `start` is accepted through the cycle of sample 63.
- `rd_en`  out  1  row buffer read strobe, one cycle per row.
- `rd_addr`  out  3  row number being read.
- `ren`  out  1  parallel-load strobe to the shift register.
- `men`  out  1  shift strobe to the shift register.
- `dout_valid`  out  1  shift register output holds a frame sample.
- `dout_idx`  out  6  sample index 8*row+lane, aligned with the shift register output.
- `dout_last`  out  1  high with `dout_idx`=63.
- `done`  out  1  one-cycle pulse, the cycle after sample 63.

## Operation
- FSM states:
  - IDLE: `start`=1 → FETCH.
  - FETCH: issue rows 0..7; after row 7 is issued → DRAIN.
  - DRAIN: wait for the last output → DONE when sample 63 is output.
  - DONE: one cycle, `done`=1 → IDLE.
- Read issue: `rd_en` for row r at cycle 1+8r, where cycle 0 is the `start` acceptance cycle. `rd_addr`=r with `rd_en`; `rd_addr` holds its last value otherwise.
- Load: `ren` = `rd_en` delayed by exactly `RD_LAT` cycles through a registered pipe. Data is therefore captured as row r arrives.
- Shift: `men`=1 in every cycle where the shift register output holds lane 0..6 of a row. `men`=0 when lane 7 is at the output.
  - For rows 0..6, lane 7 coincides with the next row's `ren`. Load wins inside the shift register, and no bubble is allowed.
  - For row 7, lane 7 has neither strobe.
- `ren` and `men` are never high in the same cycle.
- Output tagging:
  - Lane counter 0..7 and row counter 0..7 advance on each valid output cycle. `dout_idx`={row,lane}.
  - `dout_last`=1 only when `dout_idx`=63.
  - `dout_valid` is low outside the 64-cycle window.
- `start` while `busy`=1 or in DONE: ignored, with no queuing. A `start` is accepted in the first IDLE cycle after DONE.
- Reset (any state, including mid-frame): next cycle the FSM is IDLE and all outputs are 0. Counters and the `ren` pipe are cleared, so no stale `ren` escapes. Shift register contents are don't-care.

## Timing
- Reset values:
  - `busy`, `rd_en`, `ren`, `men`, `dout_valid`, `dout_last`, `done` = 0.
  - `rd_addr`, `dout_idx` = 0.
- Latency (cycle 0 = `start` sampled high in IDLE):
  - First `rd_en`: cycle 1.
  - First `ren`: cycle 1+`RD_LAT`.
  - First valid sample: cycle 2+`RD_LAT`.
- Sample 8r+k is valid at cycle 2+`RD_LAT`+8r+k. Throughput is 64 samples in 64 consecutive cycles.
- `men` cycles: 2+`RD_LAT`+8r+k for k=0..6.
- `ren` for row r+1 coincides with lane 7 of row r.
- `dout_last`: cycle 65+`RD_LAT`.
- `done`: cycle 66+`RD_LAT`.
- `busy`: high cycles 1 through 65+`RD_LAT` inclusive.
- Minimum start-to-start spacing: 67+`RD_LAT` cycles.
- All outputs are registered; there are no combinational paths from `start` to any output.

## Test plan
- Single frame, `RD_LAT`=1, row buffer word r lane k = 8r+k, `start` at cycle 0:
  - `rd_en` at cycles 1,9,…,57 with `rd_addr` 0..7.
  - `dout_valid` cycles 3..66, data equals `dout_idx`.
  - `dout_last` at 66, `done` at 67, `busy` high 1..66.
- Strobe check: over the whole frame, count of `ren`=8 and count of `men`=56. `ren`&`men` is never seen.
- `RD_LAT`=3 parameter sweep: first valid at cycle 5, `done` at 69, data still 0..63 in order.
- `start` held high continuously:
  - Second frame accepted at cycle 68 (`RD_LAT`=1).
  - No activity between `done` and that acceptance; `start` pulses during `busy` are ignored.
- `rst` at cycle 30 mid-frame:
  - From cycle 31 all outputs are 0 and no `ren` appears from the pipe.
  - A `start` at cycle 35 produces a full clean frame with index 0..63.
- `start` and `rst` asserted in the same cycle: reset wins, and the block stays IDLE.
